// File: rtl/div_seq_32bit_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_seq_32bit_pkg;

   // funct3[1:0] encoding of the four divide/remainder instructions
   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   // Quotient returned for a zero divisor
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   // Most negative 32-bit value, also the signed-overflow quotient
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   // DIV and REM are signed; the unsigned variants have funct3[0] set
   function automatic logic op_is_signed(input div_op_e op);
      return ~op[0];
   endfunction

   // REM and REMU return the remainder
   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_seq_32bit_if.sv
// Request/response bundle between the execute stage and the divider.
// The master is the execute stage, the slave is the divider.
interface div_seq_32bit_if #(
   parameter int WIDTH = 32
);
   logic             flush_i;
   logic             valid_i;
   logic             ready_o;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] c_o;

   modport master (
      output flush_i, valid_i, op_i, a_i, b_i, ready_i,
      input  ready_o, valid_o, c_o
   );

   modport slave (
      input  flush_i, valid_i, op_i, a_i, b_i, ready_i,
      output ready_o, valid_o, c_o
   );
endinterface

// File: rtl/div_seq_32bit_step.sv
// One restoring-division iteration: shift in a dividend bit, trial
// subtract the divisor, keep the difference only if it stays non-negative.
module div_seq_32bit_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           unused_rem_msb;

   // The stored remainder is always below the divisor, so its top bit is zero
   assign unused_rem_msb = rem_in[WIDTH];

   assign shifted = {rem_in[WIDTH-1:0], bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[WIDTH];
   assign rem_out = q_bit ? diff : shifted;
endmodule

// File: rtl/div_seq_32bit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Signed operands are divided as magnitudes and the sign is fixed up
// when the result is registered on entry to DONE.
module div_seq_32bit
   import div_seq_32bit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic               clk_i,
   input logic               rst_ni,
   div_seq_32bit_if.slave    bus
);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_e       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   div_op_e          op_reg;
   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] c_reg;
   logic             neg_q_reg;
   logic             neg_r_reg;

   div_op_e          op_in;
   logic             in_signed, a_neg, b_neg, div_zero, overflow, special;
   logic [WIDTH-1:0] a_abs, b_abs, special_res;
   logic [WIDTH:0]   rem_step;
   logic             q_bit;
   logic [WIDTH-1:0] q_final, r_final, calc_res;

   assign op_in = div_op_e'(bus.op_i);

   div_seq_32bit_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_reg),
      .bit_in  (dvd_reg[WIDTH-1]),
      .divisor (dsr_reg),
      .rem_out (rem_step),
      .q_bit   (q_bit)
   );

   // Operand magnitudes and the early-out cases decided at accept time
   always_comb begin
      in_signed   = op_is_signed(op_in);
      a_neg       = in_signed & bus.a_i[WIDTH-1];
      b_neg       = in_signed & bus.b_i[WIDTH-1];
      a_abs       = a_neg ? -bus.a_i : bus.a_i;
      b_abs       = b_neg ? -bus.b_i : bus.b_i;
      div_zero    = (bus.b_i == '0);
      overflow    = in_signed && (bus.a_i == INT_MIN) && (bus.b_i == '1);
      special     = div_zero | overflow;
      special_res = '0;
      if (div_zero)
         special_res = op_is_rem(op_in) ? bus.a_i : DIV_ZERO_Q;
      else
         special_res = op_is_rem(op_in) ? '0 : INT_MIN;
   end

   // Final quotient/remainder including the bit produced on the last edge
   always_comb begin
      q_final  = {dvd_reg[WIDTH-2:0], q_bit};
      r_final  = rem_step[WIDTH-1:0];
      calc_res = r_final;
      case (op_reg)
         OP_DIV:  calc_res = neg_q_reg ? -q_final : q_final;
         OP_DIVU: calc_res = q_final;
         OP_REM:  calc_res = neg_r_reg ? -r_final : r_final;
         default: calc_res = r_final;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic; a flush overrides every other transition
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.valid_i) state_next = special ? DONE : CALC;
         CALC:    if (cnt_reg == LAST_CNT) state_next = DONE;
         DONE:    if (bus.ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (bus.flush_i)
         state_next = IDLE;
   end

   // Operand latch, iteration datapath and result register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg   <= '0;
         op_reg    <= OP_DIV;
         dvd_reg   <= '0;
         dsr_reg   <= '0;
         rem_reg   <= '0;
         c_reg     <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else if (!bus.flush_i) begin
         case (state_reg)
            IDLE: begin
               if (bus.valid_i) begin
                  op_reg    <= op_in;
                  neg_q_reg <= a_neg ^ b_neg;
                  neg_r_reg <= a_neg;
                  dvd_reg   <= a_abs;
                  dsr_reg   <= b_abs;
                  rem_reg   <= '0;
                  cnt_reg   <= '0;
                  if (special)
                     c_reg <= special_res;
               end
            end
            CALC: begin
               rem_reg <= rem_step;
               dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT)
                  c_reg <= calc_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.ready_o = (state_reg == IDLE);
   assign bus.valid_o = (state_reg == DONE);
   assign bus.c_o     = c_reg;
endmodule

// File: tb/tb_div_seq_32bit.sv
// Self-checking bench for div_seq_32bit: directed corner cases plus
// randomized operations compared with an arithmetic reference model.
module tb_div_seq_32bit;
   localparam logic [1:0] OPC_DIV  = 2'b00;
   localparam logic [1:0] OPC_DIVU = 2'b01;
   localparam logic [1:0] OPC_REM  = 2'b10;
   localparam logic [1:0] OPC_REMU = 2'b11;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   chk_cnt;

   div_seq_32bit_if #(.WIDTH(32)) dif ();

   div_seq_32bit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result from RV32M arithmetic rules
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (op)
         OPC_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         OPC_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         OPC_REM: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 32;
   endfunction

   // Drive one request, scramble inputs after accept, wait for the result.
   // With hold set the result is left pending in DONE.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output logic [31:0] res, output int lat);
      @(negedge clk);
      dif.op_i    = op;
      dif.a_i     = a;
      dif.b_i     = b;
      dif.valid_i = 1'b1;
      @(posedge clk);
      #1;
      dif.valid_i = 1'b0;
      dif.op_i    = 2'($urandom);
      dif.a_i     = $urandom;
      dif.b_i     = $urandom;
      lat = 999;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (dif.valid_o) begin
            lat = i;
            break;
         end
      end
      res = dif.c_o;
      $display("txn op=%0d a=%h b=%h c=%h lat=%0d", op, a, b, res, lat);
      if (!hold) begin
         dif.ready_i = 1'b1;
         @(posedge clk);
         #1;
         dif.ready_i = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1;
      chk_cnt++;
      if (dif.ready_o !== 1'b1) $display("FAIL reset_ready got=%b want=1", dif.ready_o); else pass_cnt++;
      chk_cnt++;
      if (dif.valid_o !== 1'b0) $display("FAIL reset_valid got=%b want=0", dif.valid_o); else pass_cnt++;
      chk_cnt++;
      if (dif.c_o !== 32'd0) $display("FAIL reset_c got=%h want=00000000", dif.c_o); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Directed operand list checked for value and latency
   task automatic test_directed;
      logic [1:0]  ops [10] = '{OPC_DIVU, OPC_REMU, OPC_DIV, OPC_REM, OPC_DIV, OPC_REM,
                                OPC_DIVU, OPC_REMU, OPC_DIV, OPC_REM};
      logic [31:0] as  [10] = '{32'd100, 32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h1234, 32'h1234,
                                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [10] = '{32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], as[i], bs[i], 1'b0, res, lat);
         chk_cnt++;
         if (res !== ref_result(ops[i], as[i], bs[i]))
            $display("FAIL directed_value idx=%0d got=%h want=%h", i, res, ref_result(ops[i], as[i], bs[i]));
         else pass_cnt++;
         chk_cnt++;
         if (lat !== ref_latency(ops[i], as[i], bs[i]))
            $display("FAIL directed_latency idx=%0d got=%0d want=%0d", i, lat, ref_latency(ops[i], as[i], bs[i]));
         else pass_cnt++;
      end
   endtask

   // Random operations issued back to back with one-cycle turnaround
   task automatic test_back_to_back;
      logic [1:0]  op;
      logic [31:0] a, b, res;
      int          lat;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3:       b = 32'hFFFF_FFFF;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         run_op(op, a, b, 1'b0, res, lat);
         chk_cnt++;
         if (res !== ref_result(op, a, b))
            $display("FAIL random_value op=%0d a=%h b=%h got=%h want=%h", op, a, b, res, ref_result(op, a, b));
         else pass_cnt++;
         chk_cnt++;
         if (lat !== ref_latency(op, a, b))
            $display("FAIL random_latency op=%0d got=%0d want=%0d", op, lat, ref_latency(op, a, b));
         else pass_cnt++;
      end
   endtask

   // Result held under consumer backpressure
   task automatic test_backpressure;
      logic [31:0] res;
      int          lat;
      run_op(OPC_DIVU, 32'd1000, 32'd10, 1'b1, res, lat);
      chk_cnt++;
      if (res !== 32'd100) $display("FAIL bp_value got=%h want=%h", res, 32'd100); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk_cnt++;
         if (dif.valid_o !== 1'b1 || dif.c_o !== 32'd100 || dif.ready_o !== 1'b0)
            $display("FAIL bp_hold cyc=%0d got valid=%b c=%h ready=%b want valid=1 c=00000064 ready=0",
                     i, dif.valid_o, dif.c_o, dif.ready_o);
         else pass_cnt++;
      end
      dif.ready_i = 1'b1;
      @(posedge clk);
      #1;
      dif.ready_i = 1'b0;
      chk_cnt++;
      if (dif.ready_o !== 1'b1 || dif.valid_o !== 1'b0)
         $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", dif.ready_o, dif.valid_o);
      else pass_cnt++;
   endtask

   task automatic test_flush;
      logic [31:0] res, prev;
      int          lat, seen;
      // Flush during CALC
      @(negedge clk);
      dif.op_i = OPC_DIVU; dif.a_i = 32'd1000; dif.b_i = 32'd10; dif.valid_i = 1'b1;
      @(posedge clk);
      #1;
      dif.valid_i = 1'b0;
      chk_cnt++;
      if (dif.ready_o !== 1'b0) $display("FAIL calc_ready got=%b want=0", dif.ready_o); else pass_cnt++;
      repeat (10) @(posedge clk);
      @(negedge clk);
      dif.flush_i = 1'b1;
      @(posedge clk);
      #1;
      dif.flush_i = 1'b0;
      chk_cnt++;
      if (dif.ready_o !== 1'b1 || dif.valid_o !== 1'b0)
         $display("FAIL flush_calc got ready=%b valid=%b want ready=1 valid=0", dif.ready_o, dif.valid_o);
      else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (dif.valid_o) seen++;
      end
      chk_cnt++;
      if (seen !== 0) $display("FAIL flush_no_result got=%0d want=0", seen); else pass_cnt++;
      run_op(OPC_DIVU, 32'd9, 32'd3, 1'b0, res, lat);
      chk_cnt++;
      if (res !== 32'd3 || lat !== 32) $display("FAIL after_flush got c=%h lat=%0d want c=00000003 lat=32", res, lat);
      else pass_cnt++;

      // Flush beats a same-cycle accept
      @(negedge clk);
      dif.op_i = OPC_DIVU; dif.a_i = 32'd5; dif.b_i = 32'd0; dif.valid_i = 1'b1; dif.flush_i = 1'b1;
      @(posedge clk);
      #1;
      dif.valid_i = 1'b0; dif.flush_i = 1'b0;
      @(posedge clk);
      #1;
      chk_cnt++;
      if (dif.ready_o !== 1'b1 || dif.valid_o !== 1'b0 || dif.c_o !== 32'd3)
         $display("FAIL flush_accept got ready=%b valid=%b c=%h want ready=1 valid=0 c=00000003",
                  dif.ready_o, dif.valid_o, dif.c_o);
      else pass_cnt++;

      // Flush beats a same-cycle result handshake; c_o keeps its value
      run_op(OPC_REMU, 32'd77, 32'd10, 1'b1, prev, lat);
      @(negedge clk);
      dif.flush_i = 1'b1; dif.ready_i = 1'b1;
      @(posedge clk);
      #1;
      dif.flush_i = 1'b0; dif.ready_i = 1'b0;
      chk_cnt++;
      if (dif.valid_o !== 1'b0 || dif.ready_o !== 1'b1 || dif.c_o !== 32'd7)
         $display("FAIL flush_done got valid=%b ready=%b c=%h want valid=0 ready=1 c=00000007",
                  dif.valid_o, dif.ready_o, dif.c_o);
      else pass_cnt++;
   endtask

   // Asynchronous reset in the middle of a calculation
   task automatic test_reset_mid;
      logic [31:0] res;
      int          lat;
      @(negedge clk);
      dif.op_i = OPC_DIVU; dif.a_i = 32'd1000; dif.b_i = 32'd10; dif.valid_i = 1'b1;
      @(posedge clk);
      #1;
      dif.valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if (dif.ready_o !== 1'b1 || dif.valid_o !== 1'b0 || dif.c_o !== 32'd0)
         $display("FAIL reset_mid got ready=%b valid=%b c=%h want ready=1 valid=0 c=00000000",
                  dif.ready_o, dif.valid_o, dif.c_o);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(OPC_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, res, lat);
      chk_cnt++;
      if (res !== 32'hFFFF_FFF2) $display("FAIL after_reset got=%h want=fffffff2", res); else pass_cnt++;
   endtask

   initial begin
      pass_cnt    = 0;
      chk_cnt     = 0;
      rst_n       = 1'b0;
      dif.flush_i = 1'b0;
      dif.valid_i = 1'b0;
      dif.op_i    = 2'b00;
      dif.a_i     = 32'd0;
      dif.b_i     = 32'd0;
      dif.ready_i = 1'b0;
      repeat (3) @(posedge clk);
      test_reset;
      test_directed;
      test_backpressure;
      test_flush;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
